sync_tx_arbiter: RTL and testbench
==================================

# sync_tx_arbiter

Source-domain (clk_a) scheduler that shares one 4-bit enable-qualified clock-domain-crossing synchronizer between up to NREQ requesters. It arbitrates round-robin, drives the synchronizer's 4-bit data and enable inputs, and paces transfers. Data is held stable across the whole enable window, and the enable is held high then low long enough for the destination's two-flop enable synchronizer to capture every transfer. It sits directly in front of the synchronizer in the clk_a domain.

## Interface
- NREQ, 4: number of requesters; legal range 1..8.
- HOLD_CYC, 3: clk_a cycles sync_en stays high per transfer; at least 1.
- GAP_CYC, 3: clk_a cycles in GAP state after sync_en drops; at least 1.
- clk_a  in  1  sole clock; all logic rises on posedge.
- arstn  in  1  asynchronous, active-low reset; one clock, no second reset.
- req  in  NREQ  per-requester request level.
  - Requester holds req and its data slice until grant.
  - Requester drops req in the cycle grant is seen.
- req_data  in  4*NREQ  requester i's data is bits [4i+3:4i].
- grant  out  NREQ  one-hot, registered, single-cycle acceptance pulse.
- busy  out  1  high whenever state is not IDLE; decoded from the state register.
- sync_data  out  4  registered data to the synchronizer's data input.
- sync_en  out  1  registered enable to the synchronizer's enable input.

## Operation
- FSM states: IDLE, HOLD, GAP.
- Down-counter cnt, width clog2(max(HOLD_CYC,GAP_CYC)) with a minimum of 1.
- Round-robin pointer last (index of last granted requester).
  - Reset value of last is NREQ-1, so requester 0 has first priority.
- IDLE, at least one req bit set:
  - Select the first set bit scanning last+1, last+2, … with wrap modulo NREQ.
  - At the edge: sync_data <= selected slice; sync_en <= 1; grant <= one-hot(sel); last <= sel; cnt <= HOLD_CYC-1; state -> HOLD.
- IDLE, req == 0: all registers hold; grant = 0.
- HOLD:
  - grant cleared to 0 at the first edge in HOLD.
  - cnt != 0: decrement.
  - cnt == 0: sync_en <= 0; cnt <= GAP_CYC-1; state -> GAP.
- GAP:
  - cnt != 0: decrement.
  - cnt == 0: state -> IDLE.
- sync_data changes only at a grant edge. It holds its value through HOLD, GAP and IDLE until the next grant.
- req is ignored outside IDLE.
  - A request raised and withdrawn while busy is never granted.
  - A req still high at IDLE is treated as a new request.
- NREQ = 1: degenerate arbiter. Pacing is identical.
- Reset values, all applied asynchronously on arstn low:
  - state = IDLE, cnt = 0, last = NREQ-1.
  - sync_data = 0, sync_en = 0, grant = 0, busy = 0.
- Reset asserted mid-transfer: the in-flight transfer is abandoned, sync_en falls immediately, and no grant is reissued for it.

## Timing
- Grant latency: req high before edge k while IDLE -> grant, sync_en and sync_data valid from edge k. grant is high for exactly one cycle (k to k+1).
- sync_en high for exactly HOLD_CYC cycles (edges k to k+HOLD_CYC).
- sync_en low for at least GAP_CYC+1 cycles between transfers (GAP plus one IDLE arbitration cycle).
- Minimum transfer period: HOLD_CYC+GAP_CYC+1 cycles. This is 7 with defaults.
- busy rises at edge k and falls at edge k+HOLD_CYC+GAP_CYC.
- Back-to-back requests: the next grant occurs no earlier than edge k+HOLD_CYC+GAP_CYC+1.
- No combinational path from req or req_data to any output.

## Test plan
- Reset:
  - Stimulus: hold arstn low with random req/req_data, including mid-clock assertion.
  - Required response: sync_data=0, sync_en=0, grant=0, busy=0 immediately. The first grant after release goes to requester 0 when req=4'b1111.
- Single transfer (defaults):
  - Stimulus: req=4'b0100, req_data[11:8]=4'hA before edge k.
  - Required response: grant=4'b0100 during cycle k only; sync_data=4'hA from k; sync_en high cycles k..k+2, low from k+3; busy low from k+6.
- Round robin:
  - Stimulus: req=4'b1111; each requester drops req on its grant, with data 1,2,3,4.
  - Required response: grants in order 0,1,2,3 at 7-cycle spacing; sync_data sequence 1,2,3,4, each stable through its full HOLD+GAP window.
- Fairness:
  - Stimulus: requesters 0 and 2 re-raise req one cycle after every grant.
  - Required response: grants alternate 0,2,0,2; neither requester is granted twice in a row.
- Withdrawn request:
  - Stimulus: req[1] pulses for one cycle while busy=1.
  - Required response: grant[1] never asserts; sync_en does not re-rise after GAP.
- Reset mid-HOLD:
  - Stimulus: arstn low for 2 cycles while sync_en=1 with sync_data=4'h5.
  - Required response: sync_en=0, sync_data=0, busy=0 at once. After release with req=4'b1000, the grant goes to requester 3 with full HOLD/GAP pacing.

Source files
------------

// File: rtl/sync_tx_arbiter.sv
// Round-robin scheduler sharing one 4-bit enable-qualified CDC synchronizer
// between NREQ requesters; paces sync_en high/low so the far side sees every transfer.
module sync_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_CYC = 3,
  parameter int GAP_CYC  = 3
) (
  input  logic              clk_a,
  input  logic              arstn,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [3:0]        sync_data,
  output logic              sync_en
);

  localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
  localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned N = NREQ;

  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);
  localparam logic [LW:0]   N_EXT    = (LW+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [LW-1:0]   last, last_n, sel;
  logic [LW:0]     idx;
  logic            found;
  logic [NREQ-1:0] grant_n;
  logic [3:0]      data_n;
  logic            en_n;

  // Scan last+1 .. last+NREQ with wrap; the extra idx bit absorbs the overflow
  // before the modulo subtract so no divider is needed.
  always_comb begin
    sel   = last;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = {1'b0, last} + off[LW:0];
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!found && req[idx[LW-1:0]]) begin
        found = 1'b1;
        sel   = idx[LW-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    data_n  = sync_data;
    en_n    = sync_en;
    grant_n = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          data_n  = 4'(req_data >> {sel, 2'b00});
          en_n    = 1'b1;
          grant_n = NREQ'(1) << sel;
          last_n  = sel;
          cnt_n   = HOLD_LD;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          en_n    = 1'b0;
          cnt_n   = GAP_LD;
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else           state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= LAST_RST;
      sync_data <= '0;
      sync_en   <= 1'b0;
      grant     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last      <= last_n;
      sync_data <= data_n;
      sync_en   <= en_n;
      grant     <= grant_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Bench for sync_tx_arbiter: grant scoreboard, pacing monitor, timing vector table
// and hand-written reset / round-robin / fairness sequences.
module tb_sync_tx_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 3;
  localparam int GAP  = 3;

  logic        clk_a = 1'b0;
  logic        arstn;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  sync_data;
  logic        sync_en;

  sync_tx_arbiter #(.NREQ(NREQ), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
    .clk_a    (clk_a),
    .arstn    (arstn),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .busy     (busy),
    .sync_data(sync_data),
    .sync_en  (sync_en)
  );

  always #5 clk_a = ~clk_a;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic       en;
    logic       busy;
    logic [3:0] data;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[18];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  bit         have_last = 1'b0;
  bit         b2b = 1'b0;
  bit         mon_on = 1'b0;
  logic [3:0] held = '0;
  int         en_run = 0;
  int         busy_run = 0;
  int         rearm[4] = '{0, 0, 0, 0};
  logic [3:0] rearm_now = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sync_en"},   32'(sync_en),   32'd0);
    chk({tag, "_sync_data"}, 32'(sync_data), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_grant"},     32'(grant),     32'd0);
  endtask

  // Requesters drop req when they see grant; rearmed ones raise it again next cycle.
  task automatic run(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(posedge clk_a); #1;
      n++;
      for (int i = 0; i < 4; i++) begin
        if (rearm_now[i]) begin
          req[i] = 1'b1;
          rearm_now[i] = 1'b0;
        end
        if (grant[i]) begin
          req[i] = 1'b0;
          if (rearm[i] > 0) begin
            rearm[i]--;
            rearm_now[i] = 1'b1;
          end
        end
      end
    end
    chk("run_complete", 32'(sb.size()) + 32'(busy), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every grant and checks pacing and data stability.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_a); #1;
      cyc++;
      if (mon_on) begin
        if (!arstn) begin
          held      = '0;
          en_run    = 0;
          busy_run  = 0;
          have_last = 1'b0;
        end else begin
          if (grant != '0) begin
            if (sb.size() == 0) begin
              chk("unexpected_grant", 32'(grant), 32'd0);
            end else begin
              e = sb.pop_front();
              chk("grant_id",   32'(grant),     32'(e.grant));
              chk("grant_data", 32'(sync_data), 32'(e.data));
              chk("grant_en",   32'(sync_en),   32'd1);
              if (have_last) begin
                if (b2b) chk("grant_spacing", 32'(cyc - last_cyc), 32'(HOLD + GAP + 1));
                else     chk("grant_min_spacing", 32'(cyc - last_cyc >= HOLD + GAP + 1), 32'd1);
              end
              held      = e.data;
              last_cyc  = cyc;
              have_last = 1'b1;
            end
          end else begin
            chk("data_held", 32'(sync_data), 32'(held));
          end
          if (sync_en) en_run++;
          else if (en_run != 0) begin
            chk("en_high_len", 32'(en_run), 32'(HOLD));
            en_run = 0;
          end
          if (busy) busy_run++;
          else if (busy_run != 0) begin
            chk("busy_len", 32'(busy_run), 32'(HOLD + GAP));
            busy_run = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    // {req before edge, grant, sync_en, busy, sync_data} sampled after each edge
    tbl[0]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 4'hA};
    tbl[1]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'hA};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'hA};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'hA};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'hA};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'hA};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'hA};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'hA};
    tbl[8]  = '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'h7};
    tbl[9]  = '{4'b0010, 4'b0000, 1'b1, 1'b1, 4'h7};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'h7};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'h7};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'h7};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'h7};
    tbl[14] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'h7};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'h7};
    tbl[16] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'h7};
    tbl[17] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'h7};

    // Reset asserted mid-cycle with random requests present
    arstn    = 1'b1;
    req      = 4'($urandom);
    req_data = 16'($urandom);
    #3 arstn = 1'b0;
    #1 mon_on = 1'b1;
    chk_reset("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_a); #1;
      req      = 4'($urandom);
      req_data = 16'($urandom);
      chk_reset("rst_hold");
    end

    // Round robin from reset: requester 0 first, then 1,2,3 back to back
    req      = 4'b1111;
    req_data = 16'h4321;
    sb.push_back('{4'b0001, 4'h1});
    sb.push_back('{4'b0010, 4'h2});
    sb.push_back('{4'b0100, 4'h3});
    sb.push_back('{4'b1000, 4'h4});
    b2b   = 1'b1;
    arstn = 1'b1;
    run(80);
    b2b = 1'b0;

    // Fairness: 0 and 2 re-raise one cycle after each grant
    req_data = 16'h0C0B;
    req      = 4'b0101;
    rearm[0] = 1;
    rearm[2] = 1;
    sb.push_back('{4'b0001, 4'hB});
    sb.push_back('{4'b0100, 4'hC});
    sb.push_back('{4'b0001, 4'hB});
    sb.push_back('{4'b0100, 4'hC});
    have_last = 1'b0;
    b2b       = 1'b1;
    run(80);
    b2b = 1'b0;

    // Single transfer timing, then a request pulsed while busy is ignored
    req_data = 16'h3A57;
    sb.push_back('{4'b0100, 4'hA});
    sb.push_back('{4'b0001, 4'h7});
    for (int i = 0; i < 18; i++) begin
      req = tbl[i].req;
      @(posedge clk_a); #1;
      chk($sformatf("vec%0d_grant", i),     32'(grant),     32'(tbl[i].grant));
      chk($sformatf("vec%0d_sync_en", i),   32'(sync_en),   32'(tbl[i].en));
      chk($sformatf("vec%0d_busy", i),      32'(busy),      32'(tbl[i].busy));
      chk($sformatf("vec%0d_sync_data", i), 32'(sync_data), 32'(tbl[i].data));
    end
    req = '0;

    // Reset during HOLD abandons the transfer; pointer restarts at NREQ-1
    req_data = 16'h0050;
    req      = 4'b0010;
    sb.push_back('{4'b0010, 4'h5});
    w = 0;
    do begin
      @(posedge clk_a); #1;
      w++;
    end while (!grant[1] && w < 20);
    chk("midhold_grant_seen", 32'(grant[1]), 32'd1);
    req = '0;
    @(posedge clk_a); #1;
    chk("midhold_pre_en",   32'(sync_en),   32'd1);
    chk("midhold_pre_data", 32'(sync_data), 32'h5);
    #3 arstn = 1'b0;
    #1 chk_reset("midhold_rst");
    @(posedge clk_a);
    @(posedge clk_a); #1;
    chk_reset("midhold_rst_held");
    req_data = 16'h9000;
    req      = 4'b1000;
    sb.push_back('{4'b1000, 4'h9});
    arstn = 1'b1;
    run(40);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
